system_request_arbiter: RTL and testbench

SYSTEM_REQUEST_ARBITER -- requirements
Module: system_request_arbiter

---
 rtl/system_request_arbiter.sv | 248 ++++++++++++++++++++++++
 tb/tb_system_request_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/system_request_arbiter.sv
// -----------------------------------------------------------------------------
// system_request_arbiter
//
// Purpose:
//   Round-robin arbiter that collects requests from NUM_REQ requesters and
//   forwards one per cycle into a single registered output stage feeding a
//   downstream queue. Each forwarded request gets a 32-bit sequence ID and a
//   64-bit acceptance timestamp. Requests whose rd/wr flags are both set or
//   both clear are malformed: they are accepted, never forwarded, and counted
//   in a saturating drop counter.
//
// Optional feature (macro SYSTEM_REQUEST_ARBITER_LOCK_EN):
//   Adds in_lock. A forwarded acceptance with in_lock[i]=1 pins the grant to
//   requester i until i has a forwarded acceptance with in_lock[i]=0, or i
//   drops in_valid for a cycle. Without the macro, arbitration is pure
//   round-robin and in_lock does not exist.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   in_valid      per-requester request valid                  [NUM_REQ]
//   in_ready      per-requester accept (one-hot or zero)       [NUM_REQ]
//   in_rd_en      per-requester read flag                      [NUM_REQ]
//   in_wr_en      per-requester write flag                     [NUM_REQ]
//   in_addr       packed addresses, requester i in slice i     [NUM_REQ*ADDR_W]
//   in_wdata      packed write data, requester i in slice i    [NUM_REQ*DATA_W]
//   in_lock       (LOCK_EN only) per-requester grant lock      [NUM_REQ]
//   out_valid     output register holds a request
//   out_ready     downstream accepts the output register
//   out_rd_en     forwarded read flag
//   out_wr_en     forwarded write flag
//   out_addr      forwarded address                            [ADDR_W]
//   out_wdata     forwarded write data                         [DATA_W]
//   out_src       originating requester index                  [SRC_W]
//   request_id    ID of the request in the output register     [32]
//   out_stamp     global_cycle value at acceptance             [64]
//   global_cycle  free-running cycle counter                   [64]
//   req_fire      out_valid & out_ready
//   drop_count    saturating count of malformed requests       [16]
// -----------------------------------------------------------------------------
module system_request_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          in_valid,
    output logic [NUM_REQ-1:0]          in_ready,
    input  logic [NUM_REQ-1:0]          in_rd_en,
    input  logic [NUM_REQ-1:0]          in_wr_en,
    input  logic [NUM_REQ*ADDR_W-1:0]   in_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   in_wdata,
`ifdef SYSTEM_REQUEST_ARBITER_LOCK_EN
    input  logic [NUM_REQ-1:0]          in_lock,
`endif
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_rd_en,
    output logic                        out_wr_en,
    output logic [ADDR_W-1:0]           out_addr,
    output logic [DATA_W-1:0]           out_wdata,
    output logic [SRC_W-1:0]            out_src,
    output logic [31:0]                 request_id,
    output logic [63:0]                 out_stamp,
    output logic [63:0]                 global_cycle,
    output logic                        req_fire,
    output logic [15:0]                 drop_count
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic               r_out_valid;
    logic               r_out_rd_en;
    logic               r_out_wr_en;
    logic [ADDR_W-1:0]  r_out_addr;
    logic [DATA_W-1:0]  r_out_wdata;
    logic [SRC_W-1:0]   r_out_src;
    logic [31:0]        r_request_id;
    logic [63:0]        r_out_stamp;
    logic [31:0]        r_id_cnt;
    logic [63:0]        r_global_cycle;
    logic [15:0]        r_drop_count;
    logic [SRC_W-1:0]   r_rr_ptr;

    // ------------------------------------------------------------------
    // Unpack the per-requester address / data slices
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]  w_addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  w_wdata_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_addr_arr[gi]  = in_addr[gi*ADDR_W +: ADDR_W];
            assign w_wdata_arr[gi] = in_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Request vector seen by the arbiter (masked to the locked owner)
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0] w_req;

`ifdef SYSTEM_REQUEST_ARBITER_LOCK_EN
    logic               r_lock_active;
    logic [SRC_W-1:0]   r_lock_idx;

    // While locked only the owner is visible; the round-robin search below
    // then trivially lands on it.
    assign w_req = r_lock_active ? (in_valid & (NUM_REQ'(1) << r_lock_idx)) : in_valid;
`else
    assign w_req = in_valid;
`endif

    // ------------------------------------------------------------------
    // Round-robin search: rotate so rr_ptr sits at bit 0, pick the lowest
    // set bit, then rotate the offset back into a requester index.
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0] w_rot;
    logic               w_found;
    logic [SRC_W-1:0]   w_off;
    logic [SRC_W:0]     w_sum;
    logic [SRC_W-1:0]   w_grant;
    logic [SRC_W-1:0]   w_next_ptr;

    assign w_rot = NUM_REQ'({w_req, w_req} >> r_rr_ptr);

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_off   = SRC_W'(k);
            end
        end
    end

    assign w_sum      = {1'b0, r_rr_ptr} + {1'b0, w_off};
    assign w_grant    = (w_sum >= (SRC_W+1)'(NUM_REQ)) ? SRC_W'(w_sum - (SRC_W+1)'(NUM_REQ))
                                                      : w_sum[SRC_W-1:0];
    assign w_next_ptr = (w_grant == SRC_W'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;

    // ------------------------------------------------------------------
    // Acceptance: the output register is free when empty or draining now.
    // ------------------------------------------------------------------
    logic w_can_accept;
    logic w_accept;
    logic w_rd_sel;
    logic w_wr_sel;
    logic w_fwd;

    assign w_can_accept = ~r_out_valid | out_ready;
    assign w_accept     = w_found & w_can_accept;
    assign w_rd_sel     = in_rd_en[w_grant];
    assign w_wr_sel     = in_wr_en[w_grant];
    // Exactly one of rd/wr must be set for the request to be forwarded.
    assign w_fwd        = w_accept & (w_rd_sel ^ w_wr_sel);

    // in_ready is combinational, so gate it with reset to hold it low while
    // reset is asserted regardless of the clock.
    assign in_ready = (reset && w_accept) ? (NUM_REQ'(1) << w_grant) : '0;

    // ------------------------------------------------------------------
    // Output stage, counters and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid    <= 1'b0;
            r_out_rd_en    <= 1'b0;
            r_out_wr_en    <= 1'b0;
            r_out_addr     <= '0;
            r_out_wdata    <= '0;
            r_out_src      <= '0;
            r_request_id   <= '0;
            r_out_stamp    <= '0;
            r_id_cnt       <= '0;
            r_global_cycle <= '0;
            r_drop_count   <= '0;
            r_rr_ptr       <= '0;
        end else begin
            r_global_cycle <= r_global_cycle + 64'd1;

            if (w_accept) begin
                r_rr_ptr <= w_next_ptr;
            end

            if (w_fwd) begin
                // Load (also covers drain-and-refill in the same edge).
                r_out_valid  <= 1'b1;
                r_out_rd_en  <= w_rd_sel;
                r_out_wr_en  <= w_wr_sel;
                r_out_addr   <= w_addr_arr[w_grant];
                r_out_wdata  <= w_wdata_arr[w_grant];
                r_out_src    <= w_grant;
                r_request_id <= r_id_cnt;
                r_out_stamp  <= r_global_cycle;
                r_id_cnt     <= r_id_cnt + 32'd1;
            end else if (out_ready) begin
                r_out_valid  <= 1'b0;
            end

            if (w_accept && !w_fwd && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

`ifdef SYSTEM_REQUEST_ARBITER_LOCK_EN
    logic w_lock_sel;
    logic w_owner_valid;

    assign w_lock_sel    = in_lock[w_grant];
    assign w_owner_valid = in_valid[r_lock_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lock_active <= 1'b0;
            r_lock_idx    <= '0;
        end else if (w_fwd) begin
            // While locked, any forwarded grant necessarily belongs to the owner.
            r_lock_active <= w_lock_sel;
            r_lock_idx    <= w_grant;
        end else if (r_lock_active && !w_owner_valid) begin
            r_lock_active <= 1'b0;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid    = r_out_valid;
    assign out_rd_en    = r_out_rd_en;
    assign out_wr_en    = r_out_wr_en;
    assign out_addr     = r_out_addr;
    assign out_wdata    = r_out_wdata;
    assign out_src      = r_out_src;
    assign request_id   = r_request_id;
    assign out_stamp    = r_out_stamp;
    assign global_cycle = r_global_cycle;
    assign drop_count   = r_drop_count;
    assign req_fire     = r_out_valid & out_ready;

endmodule

// File: tb/tb_system_request_arbiter.sv
// -----------------------------------------------------------------------------
// tb_system_request_arbiter
//
// Directed testbench for system_request_arbiter (default parameters). Walks
// through reset, round-robin streaming, back-pressure, malformed drops with
// drop-counter saturation, ID wrap, mid-operation reset and, when built with
// SYSTEM_REQUEST_ARBITER_LOCK_EN, grant locking. Expected values are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_system_request_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int SRC_W   = 2;

    logic                       clk;
    logic                       reset;
    logic [NUM_REQ-1:0]         in_valid;
    logic [NUM_REQ-1:0]         in_ready;
    logic [NUM_REQ-1:0]         in_rd_en;
    logic [NUM_REQ-1:0]         in_wr_en;
    logic [NUM_REQ*ADDR_W-1:0]  in_addr;
    logic [NUM_REQ*DATA_W-1:0]  in_wdata;
`ifdef SYSTEM_REQUEST_ARBITER_LOCK_EN
    logic [NUM_REQ-1:0]         in_lock;
`endif
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_rd_en;
    logic                       out_wr_en;
    logic [ADDR_W-1:0]          out_addr;
    logic [DATA_W-1:0]          out_wdata;
    logic [SRC_W-1:0]           out_src;
    logic [31:0]                request_id;
    logic [63:0]                out_stamp;
    logic [63:0]                global_cycle;
    logic                       req_fire;
    logic [15:0]                drop_count;

    int tests  = 0;
    int failed = 0;

    system_request_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rd_en     (in_rd_en),
        .in_wr_en     (in_wr_en),
        .in_addr      (in_addr),
        .in_wdata     (in_wdata),
`ifdef SYSTEM_REQUEST_ARBITER_LOCK_EN
        .in_lock      (in_lock),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rd_en    (out_rd_en),
        .out_wr_en    (out_wr_en),
        .out_addr     (out_addr),
        .out_wdata    (out_wdata),
        .out_src      (out_src),
        .request_id   (request_id),
        .out_stamp    (out_stamp),
        .global_cycle (global_cycle),
        .req_fire     (req_fire),
        .drop_count   (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        reset     = 1'b0;
        in_valid  = 4'b1111;
        in_rd_en  = 4'b1111;
        in_wr_en  = 4'b0000;
        out_ready = 1'b1;
`ifdef SYSTEM_REQUEST_ARBITER_LOCK_EN
        in_lock   = 4'b0000;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            in_addr[i*ADDR_W +: ADDR_W]  = 32'hA000_0000 + 32'(i);
            in_wdata[i*DATA_W +: DATA_W] = 32'hD000_0000 + 32'(i);
        end
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_global_cycle", global_cycle, 64'd0);
        check("rst_drop_count", 64'(drop_count), 64'd0);
        check("rst_request_id", 64'(request_id), 64'd0);
        check("rst_out_addr", 64'(out_addr), 64'd0);
        $display("[TB] reset state checked");

        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;

        // ---------------- round-robin streaming ----------------
        for (int k = 0; k < 5; k++) begin
            check("rr_in_ready", 64'(in_ready), 64'(4'b0001 << (k % 4)));
            tick();
            check("rr_out_src", 64'(out_src), 64'(k % 4));
            check("rr_request_id", 64'(request_id), 64'(k));
            check("rr_out_stamp", out_stamp, 64'(k));
            check("rr_req_fire", 64'(req_fire), 64'd1);
            check("rr_global_cycle", global_cycle, 64'(k + 1));
            check("rr_out_addr", 64'(out_addr), 64'(32'hA000_0000 + 32'(k % 4)));
            $display("[TB] stream #%0d src=%0d id=%0d stamp=%0d", k, out_src, request_id, out_stamp);
        end

        // ---------------- back-pressure ----------------
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("stall_in_ready", 64'(in_ready), 64'd0);
            tick();
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_out_addr", 64'(out_addr), 64'h0000_0000_A000_0000);
            check("stall_request_id", 64'(request_id), 64'd4);
            check("stall_out_stamp", out_stamp, 64'd4);
            $display("[TB] stall cycle %0d id=%0d", k, request_id);
        end
        out_ready = 1'b1;
        #1;
        check("drain_in_ready", 64'(in_ready), 64'b0010);
        tick();
        check("drain_out_src", 64'(out_src), 64'd1);
        check("drain_request_id", 64'(request_id), 64'd5);
        check("drain_out_stamp", out_stamp, 64'd10);
        check("drain_out_valid", 64'(out_valid), 64'd1);
        $display("[TB] drain+accept id=%0d stamp=%0d", request_id, out_stamp);

        // ---------------- malformed request ----------------
        in_valid = 4'b0100;
        in_wr_en = 4'b0100;
        #1;
        check("bad_in_ready", 64'(in_ready), 64'b0100);
        tick();
        check("bad_out_valid", 64'(out_valid), 64'd0);
        check("bad_drop_count", 64'(drop_count), 64'd1);
        check("bad_req_fire", 64'(req_fire), 64'd0);
        in_valid = 4'b0001;
        in_wr_en = 4'b0000;
        #1;
        check("post_bad_in_ready", 64'(in_ready), 64'b0001);
        tick();
        check("post_bad_request_id", 64'(request_id), 64'd6);
        check("post_bad_out_src", 64'(out_src), 64'd0);
        $display("[TB] malformed drop=%0d next id=%0d", drop_count, request_id);

        // ---------------- drop counter saturation ----------------
        in_valid = 4'b0100;
        in_wr_en = 4'b0100;
        repeat (65533) tick();
        check("sat_drop_fffe", 64'(drop_count), 64'hFFFE);
        repeat (7) tick();
        check("sat_drop_ffff", 64'(drop_count), 64'hFFFF);
        check("sat_out_valid", 64'(out_valid), 64'd0);
        $display("[TB] saturation drop=0x%0h", drop_count);

        // ---------------- request ID wrap ----------------
        in_valid = 4'b0000;
        in_wr_en = 4'b0000;
        force dut.r_id_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_id_cnt;
        in_valid = 4'b0001;
        #1;
        check("wrap_in_ready", 64'(in_ready), 64'b0001);
        tick();
        check("wrap_id_max", 64'(request_id), 64'hFFFF_FFFF);
        in_valid = 4'b0010;
        tick();
        check("wrap_id_zero", 64'(request_id), 64'd0);
        check("wrap_out_src", 64'(out_src), 64'd1);
        $display("[TB] id wrap src=%0d id=0x%0h", out_src, request_id);

        // ---------------- reset mid-operation ----------------
        out_ready = 1'b0;
        in_valid  = 4'b0000;
        tick();
        check("pre_rst_out_valid", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_global_cycle", global_cycle, 64'd0);
        check("mid_rst_drop_count", 64'(drop_count), 64'd0);
        check("mid_rst_out_src", 64'(out_src), 64'd0);
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 4'b0001;
        out_ready = 1'b1;
        #1;
        check("post_rst_req_fire", 64'(req_fire), 64'd0);
        check("post_rst_in_ready", 64'(in_ready), 64'b0001);
        tick();
        check("post_rst_request_id", 64'(request_id), 64'd0);
        check("post_rst_out_stamp", out_stamp, 64'd0);
        check("post_rst_global_cycle", global_cycle, 64'd1);
        $display("[TB] post-reset id=%0d stamp=%0d", request_id, out_stamp);

`ifdef SYSTEM_REQUEST_ARBITER_LOCK_EN
        // ---------------- grant lock ----------------
        in_valid = 4'b1111;
        for (int j = 0; j < 3; j++) begin
            in_lock = (j < 2) ? 4'b0010 : 4'b0000;
            #1;
            check("lock_in_ready", 64'(in_ready), 64'b0010);
            tick();
            check("lock_out_src", 64'(out_src), 64'd1);
            check("lock_request_id", 64'(request_id), 64'(j + 1));
            $display("[TB] lock step %0d src=%0d id=%0d", j, out_src, request_id);
        end
        in_lock = 4'b0000;
        #1;
        check("unlock_in_ready", 64'(in_ready), 64'b0100);
        tick();
        check("unlock_out_src", 64'(out_src), 64'd2);
        $display("[TB] unlocked src=%0d", out_src);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
